avst_ram_writer: RTL

AVST_RAM_WRITER -- requirements
Module: avst_ram_writer

---
 rtl/avst_pkg.sv | 20 ++
 rtl/avst_ram_writer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/avst_pkg.sv
// Shared types and constants for the Avalon-ST to RAM packet writer.
// Holds the FSM state encoding, error bit positions and default sizes.
package avst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2,
    ST_FULL = 2'd3
  } state_t;

  localparam int ERR_NOSOP   = 0;
  localparam int ERR_SOP_MID = 1;
  localparam int ERR_OVF     = 2;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_ADDR_W = 10;
  localparam int CNT_W      = 10;

endpackage

// File: rtl/avst_ram_writer.sv
// Avalon-ST sink that stores whole packets into an external single-port RAM
// and reports each committed packet's base address, length and empty count.
module avst_ram_writer
  import avst_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int EMPTY_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [WIDTH-1:0]   snk_data,
  input  logic               snk_valid,
  output logic               snk_ready,
  input  logic               snk_sop,
  input  logic               snk_eop,
  input  logic [EMPTY_W-1:0] snk_empty,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [WIDTH-1:0]   ram_data,
  output logic               ram_wren,
  output logic               pkt_done,
  output logic [ADDR_W-1:0]  pkt_base,
  output logic [ADDR_W:0]    pkt_len,
  output logic [EMPTY_W-1:0] pkt_empty,
  output logic [2:0]         err,
  output logic [15:0]        leds
);

  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'((1 << ADDR_W) - 1);
  localparam logic [ADDR_W:0] END_PTR  = (ADDR_W+1)'(1 << ADDR_W);

  state_t             state;
  logic [ADDR_W:0]    wr_ptr;
  logic [ADDR_W:0]    pkt_start;
  logic [ADDR_W:0]    beat_cnt;
  logic [CNT_W-1:0]   pkt_count;

  logic               acc;
  logic               start_beat;
  logic               cont_beat;
  logic               wr_beat;
  logic [ADDR_W:0]    wr_addr;
  logic               at_end;
  logic [ADDR_W:0]    cnt_next;

  assign snk_ready = (state != ST_FULL);
  assign leds      = {state, (state == ST_FULL), err, pkt_count};

  // A sop inside a packet restarts it at pkt_start, so the write address is
  // selected before the beat classification is used by the FSM.
  always_comb begin
    acc        = snk_valid & snk_ready;
    start_beat = acc & snk_sop & ((state == ST_IDLE) | (state == ST_RECV));
    cont_beat  = acc & ~snk_sop & (state == ST_RECV);
    wr_beat    = start_beat | cont_beat;
    if ((state == ST_RECV) && snk_sop) begin
      wr_addr = pkt_start;
    end else begin
      wr_addr = wr_ptr;
    end
    at_end = (wr_addr == LAST_PTR);
    if (start_beat) begin
      cnt_next = (ADDR_W+1)'(1);
    end else begin
      cnt_next = beat_cnt + (ADDR_W+1)'(1);
    end
  end

  // Packet FSM with registered RAM write port and commit reporting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      pkt_start <= '0;
      beat_cnt  <= '0;
      ram_wren  <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= '0;
      pkt_done  <= 1'b0;
      pkt_base  <= '0;
      pkt_len   <= '0;
      pkt_empty <= '0;
      err       <= 3'b000;
      pkt_count <= '0;
    end else if (clear) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      ram_wren <= 1'b0;
      pkt_done <= 1'b0;
    end else begin
      ram_wren <= wr_beat;
      pkt_done <= 1'b0;
      if (wr_beat) begin
        ram_addr <= wr_addr[ADDR_W-1:0];
        ram_data <= snk_data;
      end
      case (state)
        ST_IDLE, ST_RECV: begin
          if (wr_beat) begin
            beat_cnt <= cnt_next;
            if (start_beat) begin
              pkt_start <= wr_addr;
            end
            if (start_beat && (state == ST_RECV)) begin
              err[ERR_SOP_MID] <= 1'b1;
            end
            if (snk_eop) begin
              pkt_done  <= 1'b1;
              pkt_base  <= start_beat ? wr_addr[ADDR_W-1:0] : pkt_start[ADDR_W-1:0];
              pkt_len   <= cnt_next;
              pkt_empty <= snk_empty;
              pkt_count <= pkt_count + CNT_W'(1);
              wr_ptr    <= wr_addr + (ADDR_W+1)'(1);
              state     <= at_end ? ST_FULL : ST_IDLE;
            end else if (at_end) begin
              // Last word reached mid-packet: rewind so the slot is reused.
              err[ERR_OVF] <= 1'b1;
              wr_ptr       <= start_beat ? wr_addr : pkt_start;
              state        <= ST_DROP;
            end else begin
              wr_ptr <= wr_addr + (ADDR_W+1)'(1);
              state  <= ST_RECV;
            end
          end else if (acc) begin
            err[ERR_NOSOP] <= 1'b1;
            state          <= snk_eop ? ST_IDLE : ST_DROP;
          end else begin
            state <= state;
          end
        end
        ST_DROP: begin
          if (acc && snk_eop) begin
            state <= (wr_ptr == END_PTR) ? ST_FULL : ST_IDLE;
          end else begin
            state <= ST_DROP;
          end
        end
        ST_FULL: begin
          state <= ST_FULL;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
